axi4_stream_pkt_gen: RTL
========================

# axi4_stream_pkt_gen

AXI4-Stream packet transmitter that produces configurable-length packets with a deterministic byte pattern on an `axi4_stream_if.master` port. It is the source-side counterpart of our packet FIFOs: it drives their slave input in benches and in on-chip loopback/self-test paths. Software or a test FSM programs the packet size, the packet count and the inter-packet gap, then pulses start.

## Interface
- TDATA_WIDTH, 32, data bus width in bits (multiple of 8, ≥ 16).
- TUSER_WIDTH, 1, tuser width; bit 0 is start-of-packet, other bits are 0.
- TDEST_WIDTH, 1, tdest width.
- TID_WIDTH, 1, tid width.
- PKT_SIZE_WIDTH, 16, width of the packet byte-length field.
- GAP_WIDTH, 8, width of the inter-packet idle-cycle field.
- clk_i  input  1  clock; one clock domain.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  single-cycle start pulse; ignored while busy_o = 1.
- stop_i  input  1  request stop after the current packet.
- pkt_size_i  input  PKT_SIZE_WIDTH  packet length in bytes; latched on start.
- pkts_amount_i  input  16  number of packets, 0 = continuous; latched on start.
- gap_i  input  GAP_WIDTH  idle cycles between packets; latched on start.
- tdest_i / tid_i  input  TDEST_WIDTH / TID_WIDTH  driven onto every word; latched on start.
- busy_o  output  1  1 from the cycle after an accepted start until return to IDLE.
- pkts_sent_o  output  32  packets fully handshaken since reset; wraps.
- pkt_o  axi4_stream_if.master  generated stream.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE → SEND on start_i with pkt_size_i ≠ 0. start_i with pkt_size_i = 0 is ignored.
- SEND emits ceil(size / TDATA_WIDTH_B) words. Byte k of a packet (k = 0, 1, ...) carries k[7:0]. Byte lane j of word w carries byte index w·TDATA_WIDTH_B + j.
- Word counter advances only on tvalid && tready.
- tlast is on the final word. On that word, tkeep = tstrb = mask with the low (size mod TDATA_WIDTH_B) bits set, or all ones if the remainder is 0. All other words have all-ones tkeep and tstrb. Bytes outside tkeep are 0.
- tuser[0] = 1 on the first word of every packet only.
- On the last-word handshake, pkts_sent_o increments and a remaining-packet counter decrements when pkts_amount ≠ 0.
- Exit from SEND:
  - to IDLE if the remaining count reaches 0 or a stop is pending;
  - else to GAP if gap ≠ 0;
  - else stay in SEND with a new packet.
- GAP holds tvalid = 0 for exactly gap cycles, then enters SEND. A stop pending in GAP → IDLE at the end of the gap.
- stop_i sets a sticky stop-pending flag. It never truncates a packet. The flag clears on entry to IDLE.
- AXI rules: once tvalid = 1, tvalid and all payload signals stay stable until tready. tvalid never depends combinationally on tready.

## Timing
- Reset values: tvalid, tlast, tuser, tkeep, tstrb, tdata = 0; tdest, tid = 0; busy_o = 0; pkts_sent_o = 0; FSM = IDLE.
- Reset mid-packet drops tvalid immediately. The packet is lost and the downstream is expected to be reset too.
- All outputs are registered.
- start_i accepted at cycle 0 → busy_o = 1 and the first word valid at cycle 1.
- With tready held at 1, an N-word packet occupies cycles 1..N.
- gap = 0: the next packet's first word is at cycle N+1, with no bubble.
- gap = G: tvalid = 0 for G cycles, and the next first word is at cycle N+G+1.
- busy_o falls in the cycle after the final last-word handshake.
- stop_i and the last-word handshake in the same cycle → that packet is the final packet.
- start_i in the same cycle busy_o falls is ignored.

## Structure
- Package axi4_stream_pkt_gen_pkg: state enum (IDLE, SEND, GAP) and a function that computes the last-word tkeep mask from a byte remainder.
- One sub-module, axi4_stream_pkt_gen_word: a combinational word builder. Inputs are the word index, the packet size and the last flag; outputs are tdata, tkeep and tlast. Its outputs feed the registered output stage.

## Test plan
- 32-bit bus, size 10, amount 1, gap 0, tready = 1 → 3 words; data 0x03020100, 0x07060504, 0x00000908; last tkeep 4'b0011, tuser[0] only on word 0; pkts_sent_o = 1; busy_o low at cycle 4.
- Size 8, amount 3, gap 2 → words at cycles 1-2, 5-6, 9-10; tlast on the 2nd word of each packet, tkeep all ones.
- Random tready (50 %), size 17, amount 4 → payload stable while stalled; 20 handshakes total; byte pattern correct; pkts_sent_o = 4.
- Continuous mode (amount 0), size 4; stop_i pulsed mid-packet → the current packet completes with tlast, then IDLE; no truncated packet.
- Start with size 0, then start while busy → both ignored; busy_o and pkts_sent_o unchanged.
- Assert rst_i low during word 2 of a 5-word packet → all outputs 0 asynchronously; after release, a new start produces a complete, correctly ordered packet.

Source files
------------

// File: rtl/axi4_stream_pkt_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
//   state_e   : generator FSM states (idle, sending words, inter-packet gap)
//   last_keep : byte-enable mask for the final word of a packet
package axi4_stream_pkt_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  // Widest keep mask the helper can produce; callers slice the low bytes they need.
  localparam int unsigned MaxKeepW = 128;

  // Low 'rem' bits set; a zero remainder means the last word is full.
  function automatic logic [MaxKeepW-1:0] last_keep(input int unsigned rem,
                                                    input int unsigned bytes);
    logic [MaxKeepW-1:0] m;
    for (int unsigned i = 0; i < MaxKeepW; i++) begin
      m[i] = (rem == 0) ? (i < bytes) : (i < rem);
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle.
//   master modport : drives tvalid and payload, samples tready
//   slave modport  : samples tvalid and payload, drives tready
interface axi4_stream_if #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
) ();
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_gen_word.sv
// Combinational word builder for the packet generator.
//   word_idx_i : index of the word within the packet
//   pkt_size_i : packet length in bytes
//   last_i     : this is the final word of the packet
//   tdata_o    : byte lane j carries (word_idx_i * bytes + j)[7:0], 0 outside tkeep
//   tkeep_o    : all ones, or the remainder mask on the last word
//   tlast_o    : copy of last_i
module axi4_stream_pkt_gen_word
  import axi4_stream_pkt_gen_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH    = 32,
  parameter int unsigned PKT_SIZE_WIDTH = 16
) (
  input  logic [PKT_SIZE_WIDTH-1:0]  word_idx_i,
  input  logic [PKT_SIZE_WIDTH-1:0]  pkt_size_i,
  input  logic                       last_i,
  output logic [TDATA_WIDTH-1:0]     tdata_o,
  output logic [TDATA_WIDTH/8-1:0]   tkeep_o,
  output logic                       tlast_o
);
  localparam int unsigned BytesW = TDATA_WIDTH / 8;

  logic [MaxKeepW-1:0] mask_full;
  int unsigned         base;

  always_comb begin
    mask_full = last_keep(32'(pkt_size_i) % BytesW, BytesW);
    tkeep_o   = last_i ? mask_full[BytesW-1:0] : '1;
    tlast_o   = last_i;
    base      = 32'(word_idx_i) * BytesW;
    tdata_o   = '0;
    for (int unsigned j = 0; j < BytesW; j++) begin
      tdata_o[8*j +: 8] = tkeep_o[j] ? 8'(base + j) : 8'h00;
    end
  end
endmodule

// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet generator with deterministic byte pattern.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   start_i, stop_i   : start pulse (ignored while busy), sticky stop after current packet
//   pkt_size_i        : packet bytes; pkts_amount_i: packet count, 0 = continuous
//   gap_i             : idle cycles between packets; tdest_i/tid_i: routing fields
//   busy_o            : high while a run is in progress
//   pkts_sent_o       : packets whose last word handshook since reset
//   pkt_o             : generated stream (all outputs registered)
module axi4_stream_pkt_gen
  import axi4_stream_pkt_gen_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH    = 32,
  parameter int unsigned TUSER_WIDTH    = 1,
  parameter int unsigned TDEST_WIDTH    = 1,
  parameter int unsigned TID_WIDTH      = 1,
  parameter int unsigned PKT_SIZE_WIDTH = 16,
  parameter int unsigned GAP_WIDTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [PKT_SIZE_WIDTH-1:0] pkt_size_i,
  input  logic [15:0]               pkts_amount_i,
  input  logic [GAP_WIDTH-1:0]      gap_i,
  input  logic [TDEST_WIDTH-1:0]    tdest_i,
  input  logic [TID_WIDTH-1:0]      tid_i,
  output logic                      busy_o,
  output logic [31:0]               pkts_sent_o,
  axi4_stream_if.master             pkt_o
);
  localparam int unsigned BytesW = TDATA_WIDTH / 8;

  state_e                    state_q;
  logic [PKT_SIZE_WIDTH-1:0] size_q, word_q;
  logic [15:0]               remaining_q;
  logic                      cont_q, stop_pend_q, busy_q;
  logic [GAP_WIDTH-1:0]      gap_q, gap_cnt_q;
  logic [31:0]               pkts_sent_q;
  logic                      tvalid_q, tlast_q, tuser0_q;
  logic [TDATA_WIDTH-1:0]    tdata_q;
  logic [BytesW-1:0]         tkeep_q;
  logic [TDEST_WIDTH-1:0]    tdest_q;
  logic [TID_WIDTH-1:0]      tid_q;

  logic                      hs, start_ok, stop_eff, final_pkt, gap_end;
  logic                      load_word, drop_word;
  logic [PKT_SIZE_WIDTH-1:0] bld_idx, bld_size;
  int unsigned               nwords_m1;
  logic                      bld_last;
  logic [TDATA_WIDTH-1:0]    bld_tdata;
  logic [BytesW-1:0]         bld_tkeep;
  logic                      bld_tlast;

  always_comb begin
    hs        = tvalid_q & pkt_o.tready;
    start_ok  = (state_q == StIdle) && start_i && (pkt_size_i != '0);
    stop_eff  = stop_pend_q | stop_i;
    final_pkt = (!cont_q && (remaining_q == 16'd1)) || stop_eff;
    gap_end   = (state_q == StGap) && (gap_cnt_q == GAP_WIDTH'(1));
    // In idle the size is not latched yet, so build the first word from the input.
    bld_size  = (state_q == StIdle) ? pkt_size_i : size_q;
    bld_idx   = ((state_q == StSend) && !tlast_q) ? word_q + PKT_SIZE_WIDTH'(1) : '0;
    nwords_m1 = (32'(bld_size) + BytesW - 1) / BytesW - 1;
    bld_last  = (32'(bld_idx) == nwords_m1);
    load_word = start_ok
              | ((state_q == StSend) && hs && (!tlast_q || (!final_pkt && (gap_q == '0))))
              | (gap_end && !stop_eff);
    drop_word = ((state_q == StSend) && hs && tlast_q && (final_pkt || (gap_q != '0)))
              | (gap_end && stop_eff);
  end

  axi4_stream_pkt_gen_word #(
    .TDATA_WIDTH   (TDATA_WIDTH),
    .PKT_SIZE_WIDTH(PKT_SIZE_WIDTH)
  ) u_word (
    .word_idx_i(bld_idx),
    .pkt_size_i(bld_size),
    .last_i    (bld_last),
    .tdata_o   (bld_tdata),
    .tkeep_o   (bld_tkeep),
    .tlast_o   (bld_tlast)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      size_q      <= '0;
      word_q      <= '0;
      remaining_q <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      pkts_sent_q <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser0_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tdest_q     <= '0;
      tid_q       <= '0;
    end else begin
      if (busy_q && stop_i) stop_pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            size_q      <= pkt_size_i;
            remaining_q <= pkts_amount_i;
            cont_q      <= (pkts_amount_i == 16'd0);
            gap_q       <= gap_i;
            tdest_q     <= tdest_i;
            tid_q       <= tid_i;
            word_q      <= '0;
            busy_q      <= 1'b1;
            stop_pend_q <= 1'b0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (hs) begin
            if (!tlast_q) begin
              word_q <= word_q + PKT_SIZE_WIDTH'(1);
            end else begin
              pkts_sent_q <= pkts_sent_q + 32'd1;
              if (!cont_q) remaining_q <= remaining_q - 16'd1;
              word_q <= '0;
              if (final_pkt) begin
                state_q     <= StIdle;
                busy_q      <= 1'b0;
                stop_pend_q <= 1'b0;
              end else if (gap_q != '0) begin
                state_q   <= StGap;
                gap_cnt_q <= gap_q;
              end
            end
          end
        end
        StGap: begin
          if (gap_end) begin
            if (stop_eff) begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
            end else begin
              state_q <= StSend;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      // Registered output stage; payload only changes on a load, so it holds while stalled.
      if (load_word) begin
        tvalid_q <= 1'b1;
        tdata_q  <= bld_tdata;
        tkeep_q  <= bld_tkeep;
        tlast_q  <= bld_tlast;
        tuser0_q <= (bld_idx == '0);
      end else if (drop_word) begin
        tvalid_q <= 1'b0;
        tdata_q  <= '0;
        tkeep_q  <= '0;
        tlast_q  <= 1'b0;
        tuser0_q <= 1'b0;
      end
    end
  end

  always_comb begin
    pkt_o.tuser    = '0;
    pkt_o.tuser[0] = tuser0_q;
  end

  assign pkt_o.tvalid = tvalid_q;
  assign pkt_o.tdata  = tdata_q;
  assign pkt_o.tkeep  = tkeep_q;
  assign pkt_o.tstrb  = tkeep_q;
  assign pkt_o.tlast  = tlast_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tid    = tid_q;
  assign busy_o       = busy_q;
  assign pkts_sent_o  = pkts_sent_q;
endmodule
